// File: rtl/cpu1_memory_arbiter_pkg.sv
// Shared constants for the CPU1 program/data RAM arbiter.
// Default bus geometry for the 1024x32 single-port RAM and the requester ids.
package cpu1_memory_arb_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int CNT_W  = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LOG = 1'b1;
endpackage

// File: rtl/cpu1_memory_arbiter_if.sv
// Pipelined Avalon-MM requester bundle, one instance per arbiter port.
//   master : requester side (drives address/byteenable/read/write/writedata)
//   slave  : arbiter side   (drives waitrequest/readdata/readdatavalid)
interface cpu1_memory_arbiter_if
  import cpu1_memory_arb_pkg::*;
#(
  parameter int A_W = ADDR_W,
  parameter int D_W = DATA_W,
  parameter int B_W = BE_W
);
  logic [A_W-1:0] address;
  logic [B_W-1:0] byteenable;
  logic           read;
  logic           write;
  logic [D_W-1:0] writedata;
  logic           waitrequest;
  logic [D_W-1:0] readdata;
  logic           readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/cpu1_memory_arbiter_rr_grant.sv
// Two-way round-robin grant with a one-bit priority pointer.
//   clk, reset_n : clock, async active-low reset
//   hold         : suppresses all grants
//   req[1:0]     : per-port request
//   grant_valid  : a port is granted this cycle (combinational)
//   grant_id     : which port is granted
module cpu1_memory_rr_grant
  import cpu1_memory_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hold,
  input  logic [1:0] req,
  output logic       grant_valid,
  output logic       grant_id
);
  logic rr_ptr;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = rr_ptr;
    if (reset_n && !hold) begin
      case (req)
        2'b01:   begin grant_valid = 1'b1; grant_id = PORT_CPU; end
        2'b10:   begin grant_valid = 1'b1; grant_id = PORT_LOG; end
        2'b11:   begin grant_valid = 1'b1; grant_id = rr_ptr;   end
        default: ;
      endcase
    end
  end

  // Pointer moves only on an accepted transfer, favouring the other port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr <= PORT_CPU;
    else if (grant_valid) rr_ptr <= ~grant_id;
  end
endmodule

// File: rtl/cpu1_memory_arbiter.sv
// Round-robin arbiter sharing the single-port 1024x32 RAM between the CPU
// data master (p0) and the alarm-event logger/DMA (p1).
//   clk, reset_n       : clock, async active-low reset
//   hold               : parks the RAM (no grants, mem_clken=0)
//   p0, p1             : requester buses (slave modport)
//   mem_*              : RAM address/byteenable/chipselect/write/writedata/clken,
//                        mem_readdata returned one cycle after the address
//   p0_count, p1_count : saturating accepted-transfer counters
//   protocol_err       : sticky, read and write seen together on a port
module cpu1_memory_arbiter
  import cpu1_memory_arb_pkg::*;
#(
  parameter int ADDR_W = cpu1_memory_arb_pkg::ADDR_W,
  parameter int DATA_W = cpu1_memory_arb_pkg::DATA_W,
  parameter int BE_W   = cpu1_memory_arb_pkg::BE_W,
  parameter int CNT_W  = cpu1_memory_arb_pkg::CNT_W
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hold,
  cpu1_memory_arbiter_if.slave  p0,
  cpu1_memory_arbiter_if.slave  p1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [BE_W-1:0]       mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic [CNT_W-1:0]      p0_count,
  output logic [CNT_W-1:0]      p1_count,
  output logic                  protocol_err
);
  logic [1:0]        req;
  logic              grant_valid, grant_id;
  logic              gnt0, gnt1;
  logic              sel_read, sel_write;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q;
  logic [BE_W-1:0]   sel_be, be_q;
  logic              rd_accept, rd_pend, rd_owner;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign req = {p1.read | p1.write, p0.read | p0.write};

  cpu1_memory_rr_grant u_grant (
    .clk         (clk),
    .reset_n     (reset_n),
    .hold        (hold),
    .req         (req),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign gnt0 = grant_valid & (grant_id == PORT_CPU);
  assign gnt1 = grant_valid & (grant_id == PORT_LOG);

  assign sel_read  = grant_id ? p1.read       : p0.read;
  assign sel_write = grant_id ? p1.write      : p0.write;
  assign sel_addr  = grant_id ? p1.address    : p0.address;
  assign sel_wdata = grant_id ? p1.writedata  : p0.writedata;
  assign sel_be    = sel_write ? (grant_id ? p1.byteenable : p0.byteenable)
                               : {BE_W{1'b1}};

  // RAM registers its own inputs, so the mux feeds it directly; when idle the
  // last granted values are replayed to keep the RAM inputs quiet.
  assign mem_chipselect = grant_valid;
  assign mem_write      = grant_valid & sel_write;
  assign mem_address    = grant_valid ? sel_addr  : addr_q;
  assign mem_writedata  = grant_valid ? sel_wdata : wdata_q;
  assign mem_byteenable = grant_valid ? sel_be    : be_q;
  assign mem_clken      = reset_n & ~hold;

  assign p0.waitrequest = ~reset_n | (req[0] & ~gnt0) | hold;
  assign p1.waitrequest = ~reset_n | (req[1] & ~gnt1) | hold;

  // Read+write together is executed as a write only.
  assign rd_accept = grant_valid & sel_read & ~sel_write;

  assign rvalid0 = rd_pend & (rd_owner == PORT_CPU);
  assign rvalid1 = rd_pend & (rd_owner == PORT_LOG);
  assign p0.readdatavalid = rvalid0;
  assign p1.readdatavalid = rvalid1;
  assign p0.readdata = rvalid0 ? mem_readdata : rdata0_q;
  assign p1.readdata = rvalid1 ? mem_readdata : rdata1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_pend      <= 1'b0;
      rd_owner     <= PORT_CPU;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      p0_count     <= '0;
      p1_count     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (grant_valid) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        be_q    <= sel_be;
      end
      rd_pend <= rd_accept;
      if (rd_accept) rd_owner <= grant_id;
      if (rvalid0) rdata0_q <= mem_readdata;
      if (rvalid1) rdata1_q <= mem_readdata;
      if (gnt0 && p0_count != {CNT_W{1'b1}}) p0_count <= p0_count + 1'b1;
      if (gnt1 && p1_count != {CNT_W{1'b1}}) p1_count <= p1_count + 1'b1;
      if ((p0.read & p0.write) | (p1.read & p1.write)) protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cpu1_memory_arbiter.sv
module tb_cpu1_memory_arbiter;
  import cpu1_memory_arb_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hold = 1'b0;

  cpu1_memory_arbiter_if p0_if ();
  cpu1_memory_arbiter_if p1_if ();

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;
  logic [CW-1:0]     p0_count, p1_count;
  logic              protocol_err;

  int compared = 0;
  int mismatched = 0;

  cpu1_memory_arbiter #(.CNT_W(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hold           (hold),
    .p0             (p0_if),
    .p1             (p1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .p0_count       (p0_count),
    .p1_count       (p1_count),
    .protocol_err   (protocol_err)
  );

  always #5 clk = ~clk;

  // altsyncram model: registered address, unregistered output.
  logic [DATA_W-1:0] ram [1024];
  logic [ADDR_W-1:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write)
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_req();
    p0_if.read = 0; p0_if.write = 0; p0_if.address = '0; p0_if.writedata = '0; p0_if.byteenable = '0;
    p1_if.read = 0; p1_if.write = 0; p1_if.address = '0; p1_if.writedata = '0; p1_if.byteenable = '0;
  endtask

  task automatic drive(input int p, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    if (p == 0) begin
      p0_if.read = rd; p0_if.write = wr; p0_if.address = a; p0_if.writedata = d; p0_if.byteenable = be;
    end else begin
      p1_if.read = rd; p1_if.write = wr; p1_if.address = a; p1_if.writedata = d; p1_if.byteenable = be;
    end
  endtask

  task automatic apply_reset();
    clear_req();
    hold = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_reset();
    clear_req();
    sample();
    compared++; if (p0_if.waitrequest !== 1'b1) begin mismatched++; $display("FAIL rst_wait0 got %b want 1", p0_if.waitrequest); end
    compared++; if (p1_if.waitrequest !== 1'b1) begin mismatched++; $display("FAIL rst_wait1 got %b want 1", p1_if.waitrequest); end
    compared++; if (mem_clken !== 1'b0) begin mismatched++; $display("FAIL rst_clken got %b want 0", mem_clken); end
    compared++; if (mem_chipselect !== 1'b0) begin mismatched++; $display("FAIL rst_cs got %b want 0", mem_chipselect); end
    compared++; if (p0_if.readdata !== 32'h0) begin mismatched++; $display("FAIL rst_rdata0 got %h want 0", p0_if.readdata); end
    next_cycle();
    reset_n = 1;
    sample();
    compared++; if (p0_if.waitrequest !== 1'b0) begin mismatched++; $display("FAIL idle_wait0 got %b want 0", p0_if.waitrequest); end
    compared++; if (p1_if.waitrequest !== 1'b0) begin mismatched++; $display("FAIL idle_wait1 got %b want 0", p1_if.waitrequest); end
    compared++; if (mem_chipselect !== 1'b0) begin mismatched++; $display("FAIL idle_cs got %b want 0", mem_chipselect); end
    compared++; if (mem_clken !== 1'b1) begin mismatched++; $display("FAIL idle_clken got %b want 1", mem_clken); end
    compared++; if (p0_count !== 4'd0 || p1_count !== 4'd0) begin mismatched++; $display("FAIL idle_counts got %0d/%0d want 0/0", p0_count, p1_count); end
    compared++; if (protocol_err !== 1'b0) begin mismatched++; $display("FAIL idle_perr got %b want 0", protocol_err); end
  endtask

  task automatic test_write_read();
    apply_reset();
    drive(0, 0, 1, 10'h010, 32'hDEADBEEF, 4'hF);
    sample();
    compared++; if (p0_if.waitrequest !== 1'b0) begin mismatched++; $display("FAIL wr_wait0 got %b want 0", p0_if.waitrequest); end
    compared++; if ({mem_chipselect, mem_write} !== 2'b11) begin mismatched++; $display("FAIL wr_cs_we got %b want 11", {mem_chipselect, mem_write}); end
    compared++; if (mem_address !== 10'h010 || mem_writedata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL wr_bus got %h/%h want 010/deadbeef", mem_address, mem_writedata); end
    next_cycle();
    drive(0, 1, 0, 10'h010, 32'h0, 4'h0);
    sample();
    compared++; if (mem_write !== 1'b0 || mem_byteenable !== 4'hF) begin mismatched++; $display("FAIL rd_we_be got %b/%h want 0/f", mem_write, mem_byteenable); end
    compared++; if (p0_if.readdatavalid !== 1'b0) begin mismatched++; $display("FAIL rd_early_valid got %b want 0", p0_if.readdatavalid); end
    next_cycle();
    clear_req();
    sample();
    compared++; if (p0_if.readdatavalid !== 1'b1 || p0_if.readdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL rd_data0 got %b/%h want 1/deadbeef", p0_if.readdatavalid, p0_if.readdata); end
    compared++; if (p1_if.readdatavalid !== 1'b0) begin mismatched++; $display("FAIL rd_valid1 got %b want 0", p1_if.readdatavalid); end
    compared++; if (mem_chipselect !== 1'b0 || mem_address !== 10'h010) begin mismatched++; $display("FAIL idle_hold_addr got %b/%h want 0/010", mem_chipselect, mem_address); end
    next_cycle();
    sample();
    compared++; if (p0_if.readdatavalid !== 1'b0 || p0_if.readdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL rd_held got %b/%h want 0/deadbeef", p0_if.readdatavalid, p0_if.readdata); end
    compared++; if (p0_count !== 4'd2 || p1_count !== 4'd0) begin mismatched++; $display("FAIL wr_rd_counts got %0d/%0d want 2/0", p0_count, p1_count); end
  endtask

  task automatic test_contention();
    apply_reset();
    drive(0, 0, 1, 10'h001, 32'h11111111, 4'hF);
    next_cycle();
    clear_req();
    drive(1, 0, 1, 10'h002, 32'h22222222, 4'hF);
    next_cycle();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      logic exp_id, prev_id;
      exp_id  = logic'(k % 2);
      prev_id = ~exp_id;
      drive(0, 1, 0, 10'h001, 32'h0, 4'h0);
      drive(1, 1, 0, 10'h002, 32'h0, 4'h0);
      sample();
      compared++; if (p0_if.waitrequest !== exp_id || p1_if.waitrequest !== ~exp_id) begin mismatched++; $display("FAIL rr_wait[%0d] got %b%b want %b%b", k, p0_if.waitrequest, p1_if.waitrequest, exp_id, ~exp_id); end
      compared++; if (mem_address !== (exp_id ? 10'h002 : 10'h001)) begin mismatched++; $display("FAIL rr_addr[%0d] got %h want %h", k, mem_address, exp_id ? 10'h002 : 10'h001); end
      if (k > 0) begin
        compared++; if (p0_if.readdatavalid !== ~prev_id || p1_if.readdatavalid !== prev_id) begin mismatched++; $display("FAIL rr_valid[%0d] got %b%b want %b%b", k, p0_if.readdatavalid, p1_if.readdatavalid, ~prev_id, prev_id); end
        compared++; if ((prev_id ? p1_if.readdata : p0_if.readdata) !== (prev_id ? 32'h22222222 : 32'h11111111)) begin mismatched++; $display("FAIL rr_data[%0d] got %h", k, prev_id ? p1_if.readdata : p0_if.readdata); end
      end
      next_cycle();
    end
    clear_req();
    sample();
    compared++; if (p1_if.readdatavalid !== 1'b1 || p1_if.readdata !== 32'h22222222 || p0_if.readdatavalid !== 1'b0) begin mismatched++; $display("FAIL rr_last got %b/%h v0=%b want 1/22222222 v0=0", p1_if.readdatavalid, p1_if.readdata, p0_if.readdatavalid); end
    compared++; if (p0_count !== 4'd3 || p1_count !== 4'd3) begin mismatched++; $display("FAIL rr_counts got %0d/%0d want 3/3", p0_count, p1_count); end
  endtask

  task automatic test_byteenable();
    apply_reset();
    drive(1, 0, 1, 10'h3FF, 32'h11223344, 4'hF);
    next_cycle();
    drive(1, 0, 1, 10'h3FF, 32'h0000AB00, 4'b0010);
    sample();
    compared++; if (mem_byteenable !== 4'b0010 || mem_address !== 10'h3FF) begin mismatched++; $display("FAIL be_bus got %b/%h want 0010/3ff", mem_byteenable, mem_address); end
    next_cycle();
    drive(1, 1, 0, 10'h3FF, 32'h0, 4'h0);
    next_cycle();
    clear_req();
    sample();
    compared++; if (p1_if.readdatavalid !== 1'b1 || p1_if.readdata !== 32'h1122AB44) begin mismatched++; $display("FAIL be_data got %b/%h want 1/1122ab44", p1_if.readdatavalid, p1_if.readdata); end
    compared++; if (p0_if.readdatavalid !== 1'b0) begin mismatched++; $display("FAIL be_valid0 got %b want 0", p0_if.readdatavalid); end
  endtask

  task automatic test_hold();
    apply_reset();
    drive(0, 1, 0, 10'h001, 32'h0, 4'h0);
    next_cycle();
    hold = 1;
    drive(1, 1, 0, 10'h002, 32'h0, 4'h0);
    sample();
    compared++; if (p0_if.readdatavalid !== 1'b1 || p0_if.readdata !== 32'h11111111) begin mismatched++; $display("FAIL hold_rvalid got %b/%h want 1/11111111", p0_if.readdatavalid, p0_if.readdata); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) sample();
      compared++; if ({p0_if.waitrequest, p1_if.waitrequest, mem_clken, mem_chipselect} !== 4'b1100) begin mismatched++; $display("FAIL hold_state[%0d] got %b want 1100", c, {p0_if.waitrequest, p1_if.waitrequest, mem_clken, mem_chipselect}); end
      next_cycle();
    end
    hold = 0;
    sample();
    compared++; if (p0_if.waitrequest !== 1'b1 || p1_if.waitrequest !== 1'b0 || mem_address !== 10'h002) begin mismatched++; $display("FAIL hold_resume got %b%b/%h want 10/002", p0_if.waitrequest, p1_if.waitrequest, mem_address); end
    next_cycle();
    sample();
    compared++; if (p0_if.waitrequest !== 1'b0 || p1_if.waitrequest !== 1'b1) begin mismatched++; $display("FAIL hold_rr_next got %b%b want 01", p0_if.waitrequest, p1_if.waitrequest); end
    compared++; if (p1_if.readdatavalid !== 1'b1 || p1_if.readdata !== 32'h22222222) begin mismatched++; $display("FAIL hold_p1data got %b/%h want 1/22222222", p1_if.readdatavalid, p1_if.readdata); end
    next_cycle();
    clear_req();
    sample();
    compared++; if (p0_if.readdatavalid !== 1'b1 || p0_if.readdata !== 32'h11111111) begin mismatched++; $display("FAIL hold_p0data got %b/%h want 1/11111111", p0_if.readdatavalid, p0_if.readdata); end
    compared++; if (p0_count !== 4'd2 || p1_count !== 4'd1) begin mismatched++; $display("FAIL hold_counts got %0d/%0d want 2/1", p0_count, p1_count); end
  endtask

  task automatic test_protocol_err();
    apply_reset();
    drive(0, 1, 1, 10'h020, 32'hCAFEF00D, 4'hF);
    sample();
    compared++; if ({mem_chipselect, mem_write} !== 2'b11 || protocol_err !== 1'b0) begin mismatched++; $display("FAIL perr_wr got cs_we=%b perr=%b want 11/0", {mem_chipselect, mem_write}, protocol_err); end
    next_cycle();
    clear_req();
    sample();
    compared++; if (protocol_err !== 1'b1 || p0_if.readdatavalid !== 1'b0) begin mismatched++; $display("FAIL perr_set got perr=%b v0=%b want 1/0", protocol_err, p0_if.readdatavalid); end
    next_cycle();
    drive(0, 1, 0, 10'h020, 32'h0, 4'h0);
    next_cycle();
    clear_req();
    sample();
    compared++; if (p0_if.readdatavalid !== 1'b1 || p0_if.readdata !== 32'hCAFEF00D || protocol_err !== 1'b1) begin mismatched++; $display("FAIL perr_data got %b/%h perr=%b want 1/cafef00d/1", p0_if.readdatavalid, p0_if.readdata, protocol_err); end
    apply_reset();
    sample();
    compared++; if (protocol_err !== 1'b0) begin mismatched++; $display("FAIL perr_clear got %b want 0", protocol_err); end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    drive(0, 1, 0, 10'h020, 32'h0, 4'h0);
    next_cycle();
    reset_n = 0;
    clear_req();
    sample();
    compared++; if (p0_if.readdatavalid !== 1'b0 || p0_if.waitrequest !== 1'b1) begin mismatched++; $display("FAIL midrst got v0=%b w0=%b want 0/1", p0_if.readdatavalid, p0_if.waitrequest); end
    next_cycle();
    reset_n = 1;
    sample();
    compared++; if (p0_if.readdatavalid !== 1'b0) begin mismatched++; $display("FAIL midrst_after got %b want 0", p0_if.readdatavalid); end
  endtask

  task automatic test_saturation();
    apply_reset();
    drive(0, 0, 1, 10'h100, 32'h5, 4'hF);
    repeat (14) next_cycle();
    sample();
    compared++; if (p0_count !== 4'd14) begin mismatched++; $display("FAIL sat_pre got %0d want 14", p0_count); end
    repeat (6) next_cycle();
    clear_req();
    sample();
    compared++; if (p0_count !== 4'd15 || p1_count !== 4'd0) begin mismatched++; $display("FAIL sat_max got %0d/%0d want 15/0", p0_count, p1_count); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_byteenable();
    test_hold();
    test_protocol_err();
    test_reset_mid_read();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
